// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// game_pkg: opcodes, direction and life-state types shared by game-core blocks
// Rev 1.0
// ============================================================================
package game_pkg;

  localparam logic [3:0] OP_NOP     = 4'h0;
  localparam logic [3:0] OP_HEAL    = 4'h1;
  localparam logic [3:0] OP_DAMAGE  = 4'h2;
  localparam logic [3:0] OP_ATK_ADD = 4'h3;
  localparam logic [3:0] OP_ATK_SET = 4'h4;
  localparam logic [3:0] OP_MOVE    = 4'h5;
  localparam logic [3:0] OP_HP_SET  = 4'h6;
  localparam logic [3:0] OP_REVIVE  = 4'h7;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_ALIVE  = 2'd0,
    ST_INVULN = 2'd1,
    ST_DEAD   = 2'd2
  } life_t;

endpackage
`default_nettype wire

// File: rtl/player_unit_if.sv
`default_nettype none
// ============================================================================
// player_unit_if: instruction strobe bus into the player block
// Rev 1.0
// ============================================================================
interface player_unit_if;
  logic [15:0] instruction;
  logic        instr_valid;

  modport master (output instruction, output instr_valid);
  modport slave  (input  instruction, input  instr_valid);
endinterface
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
// tick_gen: free-running prescaler, one-cycle tick every MOVE_DIV clocks
// Rev 1.0
// ============================================================================
module tick_gen #(
  parameter int MOVE_DIV = 5_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CNT_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MOVE_DIV - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule
`default_nettype wire

// File: rtl/player_unit.sv
`default_nettype none
// ============================================================================
// player_unit: decodes game instructions into HP/attack/position with a life FSM
// Optional invincibility frames with PLAYER_IFRAME_EN.  Rev 1.0
// ============================================================================
module player_unit
  import game_pkg::*;
#(
  parameter int COORD_W      = 8,
  parameter int HP_W         = 8,
  parameter int ATK_W        = 8,
  parameter int HP_MAX       = 100,
  parameter int HP_INIT      = 50,
  parameter int ATK_INIT     = 10,
  parameter int ARENA_W      = 200,
  parameter int ARENA_H      = 200,
  parameter int SIZE         = 16,
  parameter int SPEED        = 10,
  parameter int START_X      = 100,
  parameter int START_Y      = 100,
  parameter int MOVE_DIV     = 5_000_000,
  parameter int IFRAME_TICKS = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  player_unit_if.slave         cmd,
  output logic [2*COORD_W-1:0] position,
  output logic [HP_W-1:0]      hp,
  output logic [ATK_W-1:0]     atk,
  output logic [7:0]           size,
  output logic                 is_dead,
  output logic                 invuln,
  output logic                 hit_pulse,
  output logic [31:0]          state
);

  localparam int HW = ((HP_W > 8) ? HP_W : 8) + 1;
  localparam int AW = ((ATK_W > 8) ? ATK_W : 8) + 1;
  localparam int CW = COORD_W + 1;
  localparam logic [HW-1:0] HP_CAP  = HW'(HP_MAX);
  localparam logic [AW-1:0] ATK_CAP = AW'({ATK_W{1'b1}});
  localparam logic signed [CW-1:0] STEP = CW'(SPEED);
  localparam logic signed [CW-1:0] X_LO = CW'(SIZE / 2);
  localparam logic signed [CW-1:0] X_HI = CW'(ARENA_W - SIZE / 2);
  localparam logic signed [CW-1:0] Y_LO = CW'(SIZE / 2);
  localparam logic signed [CW-1:0] Y_HI = CW'(ARENA_H - SIZE / 2);

`ifdef PLAYER_IFRAME_EN
  localparam int IF_W = (IFRAME_TICKS > 0) ? $clog2(IFRAME_TICKS + 1) : 1;
  logic [IF_W-1:0] iframe_cnt;
`else
  localparam int unused_iframe_ticks = IFRAME_TICKS;
  assign invuln = 1'b0;
`endif

  logic [3:0]         opc;
  logic [7:0]         operand;
  logic               unused_rsvd;
  logic               tick;
  life_t              life;
  logic [COORD_W-1:0] pos_x, pos_y;
  logic               pend_vld;
  dir_t               pend_dir;

  logic [HW-1:0]      heal_sum;
  logic [HP_W-1:0]    heal_val, dmg_val, hpset_val;
  logic               dmg_lethal;
  logic [AW-1:0]      atk_sum;
  logic [ATK_W-1:0]   atk_add_val;
  logic               mv_new;
  dir_t               mv_dir;
  logic [COORD_W-1:0] nx, ny;

  assign opc         = cmd.instruction[15:12];
  assign operand     = cmd.instruction[11:4];
  assign unused_rsvd = ^cmd.instruction[3:0];

  tick_gen #(.MOVE_DIV(MOVE_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Signed one-bit-wider arithmetic keeps a step below 0 from wrapping before the clamp.
  function automatic logic [COORD_W-1:0] step_clamp(
    input logic [COORD_W-1:0]  c,
    input logic                dec,
    input logic signed [CW-1:0] lo,
    input logic signed [CW-1:0] hi
  );
    logic signed [CW-1:0] v;
    v = dec ? ($signed({1'b0, c}) - STEP) : ($signed({1'b0, c}) + STEP);
    if (v < lo)      v = lo;
    else if (v > hi) v = hi;
    return v[COORD_W-1:0];
  endfunction

  always_comb begin
    heal_sum    = HW'(hp) + HW'(operand);
    heal_val    = (heal_sum > HP_CAP) ? HP_W'(HP_MAX) : heal_sum[HP_W-1:0];
    hpset_val   = (HW'(operand) > HP_CAP) ? HP_W'(HP_MAX) : HP_W'(operand);
    dmg_lethal  = (HW'(operand) >= HW'(hp));
    dmg_val     = hp - HP_W'(operand);
    atk_sum     = AW'(atk) + AW'(operand);
    atk_add_val = (atk_sum > ATK_CAP) ? {ATK_W{1'b1}} : atk_sum[ATK_W-1:0];
    mv_new      = cmd.instr_valid && (opc == OP_MOVE) && (operand[7:2] == 6'd0)
                  && (life != ST_DEAD);
    mv_dir      = mv_new ? dir_t'(operand[1:0]) : pend_dir;
    nx          = pos_x;
    ny          = pos_y;
    case (mv_dir)
      DIR_UP:   ny = step_clamp(pos_y, 1'b1, Y_LO, Y_HI);
      DIR_LEFT: nx = step_clamp(pos_x, 1'b1, X_LO, X_HI);
      DIR_DOWN: ny = step_clamp(pos_y, 1'b0, Y_LO, Y_HI);
      default:  nx = step_clamp(pos_x, 1'b0, X_LO, X_HI);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      life      <= ST_ALIVE;
      hp        <= HP_W'(HP_INIT);
      atk       <= ATK_W'(ATK_INIT);
      pos_x     <= COORD_W'(START_X);
      pos_y     <= COORD_W'(START_Y);
      pend_vld  <= 1'b0;
      pend_dir  <= DIR_UP;
      is_dead   <= 1'b0;
      hit_pulse <= 1'b0;
`ifdef PLAYER_IFRAME_EN
      invuln     <= 1'b0;
      iframe_cnt <= '0;
`endif
    end else begin
      hit_pulse <= 1'b0;
      if (cmd.instr_valid && (opc == OP_ATK_ADD)) atk <= atk_add_val;
      if (cmd.instr_valid && (opc == OP_ATK_SET)) atk <= ATK_W'(operand);

      // A MOVE arriving on the tick cycle bypasses the pending register.
      if (life == ST_DEAD) begin
        pend_vld <= 1'b0;
      end else if (tick) begin
        pend_vld <= 1'b0;
        if (mv_new || pend_vld) begin
          pos_x <= nx;
          pos_y <= ny;
        end
      end else if (mv_new) begin
        pend_vld <= 1'b1;
        pend_dir <= dir_t'(operand[1:0]);
      end

`ifdef PLAYER_IFRAME_EN
      if ((life == ST_INVULN) && tick) begin
        if (iframe_cnt <= IF_W'(1)) begin
          life       <= ST_ALIVE;
          invuln     <= 1'b0;
          iframe_cnt <= '0;
        end else begin
          iframe_cnt <= iframe_cnt - 1'b1;
        end
      end
`endif

      if (cmd.instr_valid) begin
        case (opc)
          OP_HEAL: if (life != ST_DEAD) hp <= heal_val;
          OP_DAMAGE: if ((life == ST_ALIVE) && (operand != 8'd0)) begin
            hp        <= dmg_lethal ? '0 : dmg_val;
            hit_pulse <= 1'b1;
            if (dmg_lethal) begin
              life    <= ST_DEAD;
              is_dead <= 1'b1;
            end
`ifdef PLAYER_IFRAME_EN
            else begin
              life       <= ST_INVULN;
              invuln     <= 1'b1;
              iframe_cnt <= IF_W'(IFRAME_TICKS);
            end
`endif
          end
          OP_HP_SET: begin
            hp <= hpset_val;
            if (hpset_val == '0) begin
              life    <= ST_DEAD;
              is_dead <= 1'b1;
`ifdef PLAYER_IFRAME_EN
              invuln  <= 1'b0;
`endif
            end else if (life == ST_DEAD) begin
              life    <= ST_ALIVE;
              is_dead <= 1'b0;
            end
          end
          OP_REVIVE: if (life == ST_DEAD) begin
            hp      <= HP_W'(HP_INIT);
            pos_x   <= COORD_W'(START_X);
            pos_y   <= COORD_W'(START_Y);
            life    <= ST_ALIVE;
            is_dead <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign position = {pos_x, pos_y};
  assign size     = 8'(SIZE);
  assign state    = {8'(hp), 8'(atk), 8'(pos_x), 8'(pos_y)};

endmodule
`default_nettype wire
